// File: rtl/johnson_pkg.sv
// Shared types and Johnson-code helpers for the decoder, the counter side and benches.
package johnson_pkg;

    localparam int JC_MAXW = 32;

    typedef enum logic {
        ACQ    = 1'b0,
        LOCKED = 1'b1
    } jc_state_t;

    // Codes are passed zero-extended to JC_MAXW; only the low n bits are meaningful.
    function automatic logic jc_legal(input logic [JC_MAXW-1:0] code, input int n);
        int trans;
        trans = 0;
        for (int i = 1; i < JC_MAXW; i++) begin
            if (i < n && code[i] != code[i-1]) begin
                trans++;
            end
        end
        return (trans <= 1);
    endfunction

    function automatic int jc_index(input logic [JC_MAXW-1:0] code, input int n);
        int   ones;
        logic msb;
        ones = 0;
        msb  = 1'b0;
        for (int i = 0; i < JC_MAXW; i++) begin
            if (i < n && code[i]) begin
                ones++;
            end
            if (i == n - 1) begin
                msb = code[i];
            end
        end
        return msb ? (n + (n - ones)) : ones;
    endfunction

    function automatic logic [JC_MAXW-1:0] jc_next(input logic [JC_MAXW-1:0] code, input int n);
        logic [JC_MAXW-1:0] nxt;
        logic               msb;
        nxt = '0;
        msb = 1'b0;
        for (int i = 0; i < JC_MAXW; i++) begin
            if (i == n - 1) begin
                msb = code[i];
            end
        end
        for (int i = 0; i < JC_MAXW; i++) begin
            if (i == 0) begin
                nxt[i] = ~msb;
            end else if (i < n) begin
                nxt[i] = code[i-1];
            end
        end
        return nxt;
    endfunction

endpackage

// File: rtl/jc_classify.sv
// Combinational legality check and index decode of one Johnson code sample.
module jc_classify
    import johnson_pkg::*;
#(
    parameter int N  = 4,
    parameter int CW = $clog2(2 * N)
) (
    input  logic [N-1:0]  d,
    output logic          legal,
    output logic [CW-1:0] index
);

    logic [JC_MAXW-1:0] code;

    always_comb begin
        code        = '0;
        code[N-1:0] = d;
        legal       = jc_legal(code, N);
        index       = CW'(jc_index(code, N));
    end

endmodule

// File: rtl/johnson_decoder.sv
// Johnson code receiver: decodes to an index, checks step continuity and tracks lock.
// Optional saturating error counter enabled by defining JDEC_ERRCNT_EN.
module johnson_decoder
    import johnson_pkg::*;
#(
    parameter int N        = 4,
    parameter int CW       = $clog2(2 * N),
    parameter int LOCK_CNT = 3
) (
    input  logic          c,
    input  logic          r,
    input  logic          en,
    input  logic [N-1:0]  d,
    output logic [CW-1:0] idx,
    output logic          vld,
    output logic          illegal,
    output logic          seq_err,
    output logic          locked,
    output logic [7:0]    err_cnt
);

    logic          legal;
    logic [CW-1:0] index;
    logic [CW-1:0] expected;
    logic          seeded;
    logic          good_step;
    logic          bad_step;
    logic          any_err;
    logic [3:0]    step_cnt;
    logic [3:0]    step_cnt_nxt;
    jc_state_t     state;
    jc_state_t     state_nxt;

    jc_classify #(.N(N), .CW(CW)) u_classify (
        .d     (d),
        .legal (legal),
        .index (index)
    );

    // Repeating the previous code never equals the successor, so stalls count as errors.
    always_comb begin
        expected  = (idx == CW'(2 * N - 1)) ? '0 : idx + CW'(1);
        good_step = en && legal && seeded && (index == expected);
        bad_step  = en && legal && seeded && (index != expected);
        any_err   = bad_step || (en && !legal);
    end

    always_ff @(posedge c) begin
        if (r) begin
            state    <= ACQ;
            step_cnt <= '0;
        end else begin
            state    <= state_nxt;
            step_cnt <= step_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        step_cnt_nxt = step_cnt;
        if (any_err) begin
            state_nxt    = ACQ;
            step_cnt_nxt = '0;
        end else if (good_step && state == ACQ) begin
            if (step_cnt + 4'd1 == 4'(LOCK_CNT)) begin
                state_nxt    = LOCKED;
                step_cnt_nxt = '0;
            end else begin
                step_cnt_nxt = step_cnt + 4'd1;
            end
        end
    end

    always_comb begin
        locked = (state == LOCKED);
    end

    // An illegal sample keeps idx but forces the next legal sample to re-seed.
    always_ff @(posedge c) begin
        if (r) begin
            idx     <= '0;
            vld     <= 1'b0;
            illegal <= 1'b0;
            seq_err <= 1'b0;
            seeded  <= 1'b0;
        end else begin
            vld     <= en && legal;
            illegal <= en && !legal;
            seq_err <= bad_step;
            if (en && legal) begin
                idx    <= index;
                seeded <= 1'b1;
            end else if (en) begin
                seeded <= 1'b0;
            end
        end
    end

`ifdef JDEC_ERRCNT_EN
    always_ff @(posedge c) begin
        if (r) begin
            err_cnt <= '0;
        end else if (any_err && err_cnt != 8'hFF) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`else
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_johnson_decoder.sv
// Self-checking bench for johnson_decoder (N=4): table-based reference model plus directed literals.
module tb_johnson_decoder;

    localparam int N        = 4;
    localparam int CW       = 3;
    localparam int LOCK_CNT = 3;
`ifdef JDEC_ERRCNT_EN
    localparam bit ERRCNT = 1'b1;
`else
    localparam bit ERRCNT = 1'b0;
`endif

    logic          c = 1'b0;
    logic          r;
    logic          en;
    logic [N-1:0]  d;
    logic [CW-1:0] idx;
    logic          vld;
    logic          illegal;
    logic          seq_err;
    logic          locked;
    logic [7:0]    err_cnt;

    int checks = 0;
    int errors = 0;

    logic [N-1:0] seq_table [2*N];
    int  m_idx, m_steps, m_err;
    bit  m_vld, m_illegal, m_seq_err, m_locked, m_seeded;

    johnson_decoder #(.N(N), .CW(CW), .LOCK_CNT(LOCK_CNT)) dut (
        .c       (c),
        .r       (r),
        .en      (en),
        .d       (d),
        .idx     (idx),
        .vld     (vld),
        .illegal (illegal),
        .seq_err (seq_err),
        .locked  (locked),
        .err_cnt (err_cnt)
    );

    always #5 c = ~c;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference sequence built by walking the ring: legal codes are exactly its entries.
    initial begin
        logic [N-1:0] code;
        code = '0;
        for (int k = 0; k < 2 * N; k++) begin
            seq_table[k] = code;
            code = {code[N-2:0], ~code[N-1]};
        end
    end

    function automatic int lookup(input logic [N-1:0] code);
        for (int k = 0; k < 2 * N; k++) begin
            if (seq_table[k] == code) return k;
        end
        return -1;
    endfunction

    // Reference model advances at each rising edge, outputs compared just after.
    always @(posedge c) begin
        int pos;
        if (r) begin
            m_idx = 0; m_vld = 0; m_illegal = 0; m_seq_err = 0;
            m_locked = 0; m_steps = 0; m_err = 0; m_seeded = 0;
        end else begin
            m_vld = 0; m_illegal = 0; m_seq_err = 0;
            if (en) begin
                pos = lookup(d);
                if (pos < 0) begin
                    m_illegal = 1; m_locked = 0; m_steps = 0; m_seeded = 0;
                    if (ERRCNT && m_err < 255) m_err++;
                end else begin
                    m_vld = 1;
                    if (m_seeded) begin
                        if (pos == (m_idx + 1) % (2 * N)) begin
                            if (!m_locked) begin
                                m_steps++;
                                if (m_steps == LOCK_CNT) begin
                                    m_locked = 1;
                                    m_steps  = 0;
                                end
                            end
                        end else begin
                            m_seq_err = 1; m_locked = 0; m_steps = 0;
                            if (ERRCNT && m_err < 255) m_err++;
                        end
                    end
                    m_idx = pos;
                    m_seeded = 1;
                end
            end
        end
        #1;
        checkOutput("model_idx", int'(idx), m_idx);
        checkOutput("model_vld", int'(vld), int'(m_vld));
        checkOutput("model_illegal", int'(illegal), int'(m_illegal));
        checkOutput("model_seq_err", int'(seq_err), int'(m_seq_err));
        checkOutput("model_locked", int'(locked), int'(m_locked));
        checkOutput("model_err_cnt", int'(err_cnt), m_err);
    end

    // Drive at the falling edge, return once the registered response is visible.
    task automatic applyStimulus(input logic r_v, input logic en_v, input logic [N-1:0] d_v);
        @(negedge c);
        r  = r_v;
        en = en_v;
        d  = d_v;
        @(posedge c);
        #2;
    endtask

    initial begin
        r = 1'b1; en = 1'b0; d = '0;
        applyStimulus(1, 0, 4'b0000);
        applyStimulus(1, 0, 4'b0000);
        checkOutput("reset_idx", int'(idx), 0);
        checkOutput("reset_vld", int'(vld), 0);
        checkOutput("reset_locked", int'(locked), 0);
        checkOutput("reset_err_cnt", int'(err_cnt), 0);

        applyStimulus(0, 1, 4'b0000);
        checkOutput("seed_vld", int'(vld), 1);
        applyStimulus(0, 1, 4'b0001);
        applyStimulus(0, 1, 4'b0011);
        checkOutput("pre_lock", int'(locked), 0);
        applyStimulus(0, 1, 4'b0111);
        checkOutput("lock_4th", int'(locked), 1);
        checkOutput("idx_3", int'(idx), 3);
        applyStimulus(0, 1, 4'b1111);
        applyStimulus(0, 1, 4'b1110);
        applyStimulus(0, 1, 4'b1100);
        applyStimulus(0, 1, 4'b1000);
        checkOutput("idx_7", int'(idx), 7);

        applyStimulus(0, 1, 4'b0000);
        checkOutput("wrap_idx", int'(idx), 0);
        checkOutput("wrap_locked", int'(locked), 1);
        checkOutput("wrap_seq_err", int'(seq_err), 0);
        applyStimulus(0, 1, 4'b0001);
        applyStimulus(0, 1, 4'b0011);

        applyStimulus(0, 1, 4'b1111);
        checkOutput("jump_seq_err", int'(seq_err), 1);
        checkOutput("jump_idx", int'(idx), 4);
        checkOutput("jump_locked", int'(locked), 0);
        checkOutput("jump_err_cnt", int'(err_cnt), ERRCNT ? 1 : 0);
        applyStimulus(0, 1, 4'b1110);
        applyStimulus(0, 1, 4'b1100);
        checkOutput("relock_pending", int'(locked), 0);
        applyStimulus(0, 1, 4'b1000);
        checkOutput("relock", int'(locked), 1);

        applyStimulus(0, 1, 4'b0101);
        checkOutput("ill_pulse", int'(illegal), 1);
        checkOutput("ill_vld", int'(vld), 0);
        checkOutput("ill_idx_hold", int'(idx), 7);
        checkOutput("ill_locked", int'(locked), 0);
        applyStimulus(0, 1, 4'b0111);
        checkOutput("reseed_seq_err", int'(seq_err), 0);
        checkOutput("reseed_idx", int'(idx), 3);
        applyStimulus(0, 1, 4'b1111);
        applyStimulus(0, 1, 4'b1110);
        applyStimulus(0, 1, 4'b1100);
        checkOutput("relock2", int'(locked), 1);

        applyStimulus(0, 0, 4'b1010);
        checkOutput("en0_vld", int'(vld), 0);
        checkOutput("en0_idx_hold", int'(idx), 6);
        checkOutput("en0_locked_hold", int'(locked), 1);
        applyStimulus(0, 1, 4'b1000);
        checkOutput("en1_idx", int'(idx), 7);
        applyStimulus(0, 0, 4'b0000);
        applyStimulus(0, 1, 4'b0000);
        checkOutput("en1_wrap", int'(idx), 0);
        checkOutput("en1_locked", int'(locked), 1);

        applyStimulus(0, 1, 4'b0000);
        checkOutput("stall_seq_err", int'(seq_err), 1);
        checkOutput("stall_locked", int'(locked), 0);

        applyStimulus(1, 1, 4'b0001);
        checkOutput("rst_en_idx", int'(idx), 0);
        checkOutput("rst_en_vld", int'(vld), 0);
        checkOutput("rst_en_err_cnt", int'(err_cnt), 0);
        applyStimulus(0, 1, 4'b0011);
        checkOutput("post_rst_seq_err", int'(seq_err), 0);
        checkOutput("post_rst_idx", int'(idx), 2);

        for (int i = 0; i < 300; i++) begin
            applyStimulus(0, 1, 4'b1010);
        end
        checkOutput("sat_err_cnt", int'(err_cnt), ERRCNT ? 255 : 0);

        applyStimulus(0, 0, 4'b0000);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
